// File: rtl/neopix_bit_encoder.sv
// WS2812 NRZ bit encoder: streams pixel words MSB first as high/low pulse pairs, then a latch gap.
// Define NEOPIX_RGBW_EN for 32-bit GRBW pixels; the default build uses 24-bit GRB pixels.
`timescale 1ns/1ps
module neopix_bit_encoder #(
  parameter int unsigned T0H    = 40,
  parameter int unsigned T1H    = 80,
  parameter int unsigned TBIT   = 125,
  parameter int unsigned TLATCH = 5000,
  parameter int unsigned CNT_W  = 13,
`ifdef NEOPIX_RGBW_EN
  localparam int unsigned PIX_W = 32
`else
  localparam int unsigned PIX_W = 24
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] px_data,
  input  logic             px_last,
  input  logic             px_valid,
  output logic             px_ready,
  output logic             dout,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun
);

  localparam int unsigned BIT_W = $clog2(PIX_W);

  localparam logic [CNT_W-1:0] T0HEnd   = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0] T1HEnd   = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0] T0LEnd   = CNT_W'(TBIT - T0H - 1);
  localparam logic [CNT_W-1:0] T1LEnd   = CNT_W'(TBIT - T1H - 1);
  localparam logic [CNT_W-1:0] LatchEnd = CNT_W'(TLATCH - 1);
  localparam logic [BIT_W-1:0] TopBit   = BIT_W'(PIX_W - 1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow, StLatch} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             last_q, last_d;
  logic             dout_q, dout_d;

  logic [CNT_W-1:0] high_end, low_end;
  logic             final_low;
  logic             accept;

  // Pulse lengths follow the bit currently at the head of the shift register.
  assign high_end  = shift_q[PIX_W-1] ? T1HEnd : T0HEnd;
  assign low_end   = shift_q[PIX_W-1] ? T1LEnd : T0LEnd;
  assign final_low = (state_q == StLow) && (cnt_q == low_end) && (bit_q == '0) && !last_q;
  assign accept    = px_valid && px_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      last_q  <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    shift_d = shift_q;
    bit_d   = bit_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (accept) begin
          state_d = StHigh;
          shift_d = px_data;
          last_d  = px_last;
          bit_d   = TopBit;
        end
      end
      StHigh: begin
        if (cnt_q == high_end) begin
          state_d = StLow;
          cnt_d   = '0;
        end
      end
      StLow: begin
        if (cnt_q == low_end) begin
          cnt_d = '0;
          if (bit_q != '0) begin
            state_d = StHigh;
            shift_d = shift_q << 1;
            bit_d   = bit_q - BIT_W'(1);
          end else if (last_q) begin
            state_d = StLatch;
          end else if (accept) begin
            // Back-to-back pixel: the next bit period starts without a gap.
            state_d = StHigh;
            shift_d = px_data;
            last_d  = px_last;
            bit_d   = TopBit;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StLatch: begin
        if (cnt_q == LatchEnd) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Line level is registered so it tracks the state entered on the same edge.
  assign dout_d = (state_d == StHigh);

  always_comb begin
    px_ready   = rst_n && ((state_q == StIdle) || final_low);
    busy       = (state_q != StIdle);
    frame_done = rst_n && (state_q == StLatch) && (cnt_q == LatchEnd);
    underrun   = rst_n && final_low && !px_valid;
    dout       = dout_q;
  end

endmodule

// File: tb/tb_neopix_bit_encoder.sv
// Bench for neopix_bit_encoder: per-cycle queue model of the expected waveform plus directed checks.
// Build with NEOPIX_RGBW_EN defined to exercise the 32-bit pixel variant.
`timescale 1ns/1ps
module tb_neopix_bit_encoder;

`ifdef NEOPIX_RGBW_EN
  localparam int PIX_W = 32;
  localparam logic [31:0] P1_DATA = 32'h0000_00FF;
  localparam int IDX_A = 0;
  localparam int WID_A = 40;
  localparam int IDX_B = 24;
  localparam int WID_B = 80;
`else
  localparam int PIX_W = 24;
  localparam logic [23:0] P1_DATA = 24'hFF_0000;
  localparam int IDX_A = 0;
  localparam int WID_A = 80;
  localparam int IDX_B = 8;
  localparam int WID_B = 40;
`endif
  localparam int T0H     = 40;
  localparam int T1H     = 80;
  localparam int TBIT    = 125;
  localparam int TLATCH  = 5000;
  localparam int PIX_CYC = PIX_W * TBIT;
  localparam int BOUND   = 20000;

  localparam logic [1:0] TAG_DATA  = 2'd0;
  localparam logic [1:0] TAG_FNL   = 2'd1;
  localparam logic [1:0] TAG_LEND  = 2'd2;
  localparam logic [1:0] TAG_LATCH = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PIX_W-1:0] px_data;
  logic             px_last;
  logic             px_valid;
  logic             px_ready;
  logic             dout;
  logic             busy;
  logic             frame_done;
  logic             underrun;

  neopix_bit_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .px_data    (px_data),
    .px_last    (px_last),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: bound of %0d cycles expired", name, BOUND);
  endtask

  // Model: one entry per future cycle, bit0 = dout level, bits[2:1] = cycle tag.
  logic [7:0] expq[$];

  function automatic void push_px(input logic [PIX_W-1:0] d, input logic l);
    int h;
    logic [7:0] e;
    for (int b = PIX_W - 1; b >= 0; b--) begin
      h = d[b] ? T1H : T0H;
      for (int c = 0; c < TBIT; c++) begin
        e = {5'd0, TAG_DATA, (c < h)};
        if (b == 0 && c == TBIT - 1 && !l) e[2:1] = TAG_FNL;
        expq.push_back(e);
      end
    end
    if (l) begin
      for (int c = 0; c < TLATCH; c++)
        expq.push_back({5'd0, (c == TLATCH - 1) ? TAG_LEND : TAG_LATCH, 1'b0});
    end
  endfunction

  // Observation records (cycle numbers) for the directed checks.
  int   cyc = 0;
  int   acc_q[$];
  int   rise_q[$];
  int   fd_cyc = 0;
  int   fd_cnt = 0;
  int   ur_cyc = 0;
  int   ur_cnt = 0;
  logic mon_en = 1'b0;
  logic prev_rst = 1'b0;
  logic prev_dout = 1'b0;

  logic       m_has;
  logic [7:0] m_ent;
  logic       e_ready, e_under, e_fd;

  always @(posedge clk) prev_rst <= rst_n;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (!prev_rst) expq.delete();
      m_has = (expq.size() > 0);
      m_ent = m_has ? expq.pop_front() : 8'd0;
      e_ready = rst_n && (!m_has || m_ent[2:1] == TAG_FNL);
      e_under = rst_n && m_has && (m_ent[2:1] == TAG_FNL) && !px_valid;
      e_fd    = rst_n && m_has && (m_ent[2:1] == TAG_LEND);
      chk("dout", dout, m_ent[0]);
      chk("busy", busy, m_has);
      chk("px_ready", px_ready, e_ready);
      chk("underrun", underrun, e_under);
      chk("frame_done", frame_done, e_fd);
      if (e_ready && px_valid) push_px(px_data, px_last);
      if (rst_n && px_valid && px_ready) acc_q.push_back(cyc);
      if (dout && !prev_dout) rise_q.push_back(cyc);
      if (frame_done) begin fd_cyc = cyc; fd_cnt++; end
      if (underrun) begin ur_cyc = cyc; ur_cnt++; end
      prev_dout = dout;
    end
  end

  task automatic clear_rec();
    acc_q.delete();
    rise_q.delete();
  endtask

  // Present a pixel after 'gap' idle cycles and hold it until accepted; returns at posedge+1.
  task automatic send_px(input logic [PIX_W-1:0] d, input logic l, input int gap);
    int n;
    if (gap > 0) begin
      px_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    px_data  = d;
    px_last  = l;
    px_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (px_ready) break;
      n++;
      if (n > BOUND) begin timeout("accept"); break; end
    end
    @(posedge clk);
    #1;
    px_valid = 1'b0;
    px_data  = PIX_W'($urandom);
    px_last  = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n > BOUND) begin timeout("idle"); break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fd(input int target);
    int n = 0;
    while (fd_cnt < target) begin
      @(negedge clk);
      n++;
      if (n > BOUND) begin timeout("frame_done"); break; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    int n = 0;
    while (cyc < target && n <= BOUND) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int a0, fdb, npx, gap;
    rst_n    = 1'b0;
    px_valid = 1'b0;
    px_last  = 1'b0;
    px_data  = '0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_dout", dout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_px_ready", px_ready, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single last pixel, then a second pixel offered during the latch period.
    clear_rec();
    send_px(PIX_W'(P1_DATA), 1'b1, 0);
    a0 = acc_q.size() > 0 ? acc_q[0] : 0;
    wait_cycle(a0 + PIX_CYC + 100);
    chk_int("t1_rises", rise_q.size(), PIX_W);
    if (rise_q.size() == PIX_W) begin
      chk_int("t1_latency", rise_q[0] - a0, 1);
      chk_int("t1_bit_period", rise_q[IDX_A + 1] - rise_q[IDX_A], TBIT);
      chk_int("t1_last_bit_start", rise_q[PIX_W - 1] - a0, 1 + (PIX_W - 1) * TBIT);
    end
    fdb = fd_cnt;
    send_px(PIX_W'($urandom), 1'b1, 0);
    chk_int("t1_frame_done_cyc", fd_cyc - a0, PIX_CYC + TLATCH);
    chk_int("t5_accept_after_latch", acc_q[acc_q.size() - 1], fd_cyc + 1);
    wait_fd(fdb + 2);

    // Check pulse widths on a separate non-overlapped frame.
    clear_rec();
    send_px(PIX_W'(P1_DATA), 1'b1, 0);
    begin
      int n, w;
      n = 0;
      w = 0;
      while (rise_q.size() <= IDX_B && n < BOUND) begin @(negedge clk); n++; end
      while (dout && w < BOUND) begin @(negedge clk); w++; end
      chk_int("t1_width_b", w + 1, WID_B);
    end
    wait_idle();

    // Two pixels back-to-back with valid held.
    clear_rec();
    fdb = fd_cnt;
    send_px(PIX_W'(24'h0000A5), 1'b0, 0);
    send_px(PIX_W'(24'h123456), 1'b1, 0);
    wait_fd(fdb + 1);
    chk_int("t2_accepts", acc_q.size(), 2);
    if (acc_q.size() == 2) chk_int("t2_accept_gap", acc_q[1] - acc_q[0], PIX_CYC);
    if (rise_q.size() == 2 * PIX_W)
      chk_int("t2_no_gap", rise_q[PIX_W] - rise_q[PIX_W - 1], TBIT);
    else
      chk_int("t2_rises", rise_q.size(), 2 * PIX_W);
    chk_int("t2_frame_done_cyc", fd_cyc - acc_q[0], 2 * PIX_CYC + TLATCH);
    wait_idle();

    // Non-last pixel with nothing behind it.
    clear_rec();
    send_px(PIX_W'($urandom), 1'b0, 0);
    wait_idle();
    chk_int("t3_underrun_count", ur_cnt, 1);
    chk_int("t3_underrun_cyc", ur_cyc - acc_q[0], PIX_CYC);
    repeat (5) @(negedge clk);
    chk("t3_dout_low", dout, 1'b0);
    @(posedge clk);
    #1;

    // Reset during the high phase of bit 5.
    clear_rec();
    fdb = fd_cnt;
    send_px(PIX_W'($urandom), 1'b1, 0);
    begin
      int n = 0;
      while (rise_q.size() < 6 && n < BOUND) begin @(negedge clk); n++; end
    end
    repeat (10) @(negedge clk);
    chk("t4_mid_high", dout, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_dout_after_rst", dout, 1'b0);
    chk("t4_busy_after_rst", busy, 1'b0);
    repeat (200) @(negedge clk);
    chk_int("t4_no_frame_done", fd_cnt, fdb);
    @(posedge clk);
    #1;
    clear_rec();
    send_px(PIX_W'($urandom), 1'b1, 0);
    wait_fd(fdb + 1);
    chk_int("t4_new_frame", fd_cyc - acc_q[0], PIX_CYC + TLATCH);
    wait_idle();

    // Random frames, with occasional long gaps that straddle the underrun point.
    for (int f = 0; f < 2; f++) begin
      npx = $urandom_range(1, 2);
      for (int p = 0; p < npx; p++) begin
        gap = ($urandom_range(0, 1) == 0) ? 2990 + $urandom_range(0, 20) : $urandom_range(0, 4);
        if (p == 0) gap = $urandom_range(0, 4);
        send_px(PIX_W'($urandom), (p == npx - 1), gap);
      end
      wait_idle();
    end

    chk_int("model_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
